// File: rtl/hazard_ctrl_if.sv
// Bundle of decode/exec/forwarding/scoreboard/redirect signals between the
// pipeline datapath (master) and the hazard controller (slave).
interface hazard_ctrl_if #(
    parameter int REG_ADDR_W  = 5,
    parameter int NUM_SRC     = 2,
    parameter int NUM_FWD     = 2,
    parameter int MAX_PENDING = 4
);
    localparam int SEL_W = $clog2(NUM_FWD + 1);
    localparam int CNT_W = $clog2(MAX_PENDING + 1);

    logic [NUM_SRC*REG_ADDR_W-1:0] dec_rs_addr;
    logic [NUM_SRC-1:0]            dec_rs_used;
    logic [REG_ADDR_W-1:0]         dec_rd_addr;
    logic                          dec_rd_we;
    logic                          dec_is_lc;
    logic [NUM_SRC*REG_ADDR_W-1:0] exec_rs_addr;
    logic [REG_ADDR_W-1:0]         exec_rd_addr;
    logic                          exec_rd_we;
    logic                          exec_is_load;
    logic [NUM_FWD*REG_ADDR_W-1:0] fwd_rd_addr;
    logic [NUM_FWD-1:0]            fwd_rd_we;
    logic                          lc_issue;
    logic [REG_ADDR_W-1:0]         lc_rd_addr;
    logic                          lc_done;
    logic [REG_ADDR_W-1:0]         lc_done_addr;
    logic                          redirect;
    logic [NUM_SRC*SEL_W-1:0]      forward_sel;
    logic                          stall_if;
    logic                          stall_id;
    logic                          bubble_ex;
    logic                          flush_if_id;
    logic                          flush_id_ex;
    logic [CNT_W-1:0]              pending_cnt;
    logic                          sb_err;

    modport master (
        output dec_rs_addr, dec_rs_used, dec_rd_addr, dec_rd_we, dec_is_lc,
               exec_rs_addr, exec_rd_addr, exec_rd_we, exec_is_load,
               fwd_rd_addr, fwd_rd_we, lc_issue, lc_rd_addr, lc_done,
               lc_done_addr, redirect,
        input  forward_sel, stall_if, stall_id, bubble_ex, flush_if_id,
               flush_id_ex, pending_cnt, sb_err
    );

    modport slave (
        input  dec_rs_addr, dec_rs_used, dec_rd_addr, dec_rd_we, dec_is_lc,
               exec_rs_addr, exec_rd_addr, exec_rd_we, exec_is_load,
               fwd_rd_addr, fwd_rd_we, lc_issue, lc_rd_addr, lc_done,
               lc_done_addr, redirect,
        output forward_sel, stall_if, stall_id, bubble_ex, flush_if_id,
               flush_id_ex, pending_cnt, sb_err
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding select, load-use and
// long-latency scoreboard stalls, and multi-cycle flush on exec redirect.
module hazard_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int NUM_SRC      = 2,
    parameter int NUM_FWD      = 2,
    parameter int MAX_PENDING  = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input logic          clk,
    input logic          rst_n,
    hazard_ctrl_if.slave hif
);
    localparam int NUM_REGS = 2 ** REG_ADDR_W;
    localparam int SEL_W    = $clog2(NUM_FWD + 1);
    localparam int CNT_W    = $clog2(MAX_PENDING + 1);
    localparam int FCNT_W   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FCNT_W-1:0] FLUSH_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL     = CNT_W'(MAX_PENDING);
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [NUM_REGS-1:0]      pending_q, pending_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     err_q, err_d;
    logic [0:0]               state_q, state_d;
    logic [FCNT_W-1:0]        fcnt_q, fcnt_d;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel;
    logic                     load_use, raw_hit, sb_stall, flush_active;
    logic                     issue_v, done_v, issue_inc;

    // Iterate oldest to youngest so the youngest matching stage is written last.
    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (hif.fwd_rd_we[k]
                    && hif.exec_rs_addr[i*REG_ADDR_W +: REG_ADDR_W] != '0
                    && hif.fwd_rd_addr[k*REG_ADDR_W +: REG_ADDR_W]
                       == hif.exec_rs_addr[i*REG_ADDR_W +: REG_ADDR_W]) begin
                    fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
                end
            end
        end
    end

    always_comb begin
        load_use = 1'b0;
        raw_hit  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (hif.dec_rs_used[i]) begin
                if (hif.exec_is_load && hif.exec_rd_we && hif.exec_rd_addr != '0
                    && hif.dec_rs_addr[i*REG_ADDR_W +: REG_ADDR_W] == hif.exec_rd_addr) begin
                    load_use = 1'b1;
                end
                if (pending_q[hif.dec_rs_addr[i*REG_ADDR_W +: REG_ADDR_W]]) begin
                    raw_hit = 1'b1;
                end
            end
        end
    end

    assign sb_stall = raw_hit
                    | (hif.dec_rd_we && pending_q[hif.dec_rd_addr])
                    | (hif.dec_is_lc && cnt_q == CNT_FULL);

    // Done clears before issue sets, so a same-cycle reissue keeps the bit and
    // the count stays equal to the number of set bits.
    always_comb begin
        pending_d = pending_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        issue_v   = hif.lc_issue && hif.lc_rd_addr != '0;
        done_v    = hif.lc_done && hif.lc_done_addr != '0 && pending_q[hif.lc_done_addr];
        issue_inc = issue_v && (!pending_q[hif.lc_rd_addr]
                                || (done_v && hif.lc_done_addr == hif.lc_rd_addr));
        if (hif.lc_done && !done_v) begin
            err_d = 1'b1;
        end
        if (done_v) begin
            pending_d[hif.lc_done_addr] = 1'b0;
        end
        if (issue_v) begin
            pending_d[hif.lc_rd_addr] = 1'b1;
        end
        cnt_d = cnt_q + CNT_W'(issue_inc) - CNT_W'(done_v);
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        if (hif.redirect) begin
            if (FLUSH_CYCLES > 1) begin
                state_d = ST_FLUSH;
                fcnt_d  = FLUSH_RELOAD;
            end else begin
                state_d = ST_RUN;
                fcnt_d  = '0;
            end
        end else if (state_q == ST_FLUSH) begin
            if (fcnt_q == FCNT_W'(1)) begin
                state_d = ST_RUN;
                fcnt_d  = '0;
            end else begin
                fcnt_d = fcnt_q - FCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            state_q   <= ST_RUN;
            fcnt_q    <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            state_q   <= state_d;
            fcnt_q    <= fcnt_d;
        end
    end

    assign flush_active    = hif.redirect | (state_q == ST_FLUSH);
    assign hif.forward_sel = fwd_sel;
    assign hif.stall_if    = (load_use | sb_stall) & ~flush_active;
    assign hif.stall_id    = (load_use | sb_stall) & ~flush_active;
    assign hif.bubble_ex   = (load_use | sb_stall) & ~flush_active;
    assign hif.flush_if_id = flush_active;
    assign hif.flush_id_ex = flush_active;
    assign hif.pending_cnt = cnt_q;
    assign hif.sb_err      = err_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomised and directed bench for hazard_ctrl, checked every cycle against a
// set-of-pending-registers / remaining-flush-cycles reference model.
module tb_hazard_ctrl;
    localparam int A     = 5;
    localparam int NS    = 2;
    localparam int NF    = 2;
    localparam int MP    = 4;
    localparam int FC    = 2;
    localparam int NR    = 2 ** A;
    localparam int SEL_W = $clog2(NF + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_ADDR_W(A), .NUM_SRC(NS), .NUM_FWD(NF), .MAX_PENDING(MP)) hif ();

    hazard_ctrl #(
        .REG_ADDR_W(A), .NUM_SRC(NS), .NUM_FWD(NF), .MAX_PENDING(MP), .FLUSH_CYCLES(FC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hif   (hif)
    );

    bit pend[NR];
    bit m_err;
    int flush_left;
    int vec_count = 0;
    int miss_count = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int popcnt();
        int n = 0;
        for (int r = 0; r < NR; r++) n += int'(pend[r]);
        return n;
    endfunction

    function automatic logic [A-1:0] slice_a(input logic [NF*A-1:0] v, input int idx);
        return v[idx*A +: A];
    endfunction

    task automatic clearInputs();
        hif.dec_rs_addr = '0; hif.dec_rs_used = '0; hif.dec_rd_addr = '0;
        hif.dec_rd_we = 1'b0; hif.dec_is_lc = 1'b0;
        hif.exec_rs_addr = '0; hif.exec_rd_addr = '0; hif.exec_rd_we = 1'b0;
        hif.exec_is_load = 1'b0; hif.fwd_rd_addr = '0; hif.fwd_rd_we = '0;
        hif.lc_issue = 1'b0; hif.lc_rd_addr = '0; hif.lc_done = 1'b0;
        hif.lc_done_addr = '0; hif.redirect = 1'b0;
    endtask

    task automatic resetModel();
        for (int r = 0; r < NR; r++) pend[r] = 1'b0;
        m_err = 1'b0;
        flush_left = 0;
    endtask

    // Called at a falling edge with inputs already driven; checks, then advances one cycle.
    task automatic applyStimulus();
        logic [NS*SEL_W-1:0] exp_sel;
        logic exp_lu, exp_sb, exp_flush, exp_stall;
        logic [A-1:0] rs;
        #1;
        exp_sel = '0;
        exp_lu = 1'b0;
        exp_sb = (hif.dec_rd_we && pend[hif.dec_rd_addr]) || (hif.dec_is_lc && popcnt() == MP);
        for (int i = 0; i < NS; i++) begin
            rs = hif.exec_rs_addr[i*A +: A];
            for (int k = 0; k < NF; k++) begin
                if (rs != 0 && hif.fwd_rd_we[k] && slice_a(hif.fwd_rd_addr, k) == rs) begin
                    exp_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
                    break;
                end
            end
            rs = hif.dec_rs_addr[i*A +: A];
            if (hif.dec_rs_used[i]) begin
                if (pend[rs]) exp_sb = 1'b1;
                if (hif.exec_is_load && hif.exec_rd_we && hif.exec_rd_addr != 0
                    && hif.exec_rd_addr == rs) exp_lu = 1'b1;
            end
        end
        exp_flush = hif.redirect || flush_left > 0;
        exp_stall = (exp_lu || exp_sb) && !exp_flush;
        checkOutput("fwd_sel", 32'(hif.forward_sel), 32'(exp_sel));
        checkOutput("stall_if", 32'(hif.stall_if), 32'(exp_stall));
        checkOutput("stall_id", 32'(hif.stall_id), 32'(exp_stall));
        checkOutput("bubble_ex", 32'(hif.bubble_ex), 32'(exp_stall));
        checkOutput("flush_if_id", 32'(hif.flush_if_id), 32'(exp_flush));
        checkOutput("flush_id_ex", 32'(hif.flush_id_ex), 32'(exp_flush));
        checkOutput("pending_cnt", 32'(hif.pending_cnt), 32'(popcnt()));
        checkOutput("sb_err", 32'(hif.sb_err), 32'(m_err));
        if (hif.lc_done) begin
            if (hif.lc_done_addr != 0 && pend[hif.lc_done_addr]) pend[hif.lc_done_addr] = 1'b0;
            else m_err = 1'b1;
        end
        if (hif.lc_issue && hif.lc_rd_addr != 0) pend[hif.lc_rd_addr] = 1'b1;
        if (hif.redirect) flush_left = FC - 1;
        else if (flush_left > 0) flush_left--;
        @(negedge clk);
    endtask

    task automatic doReset(input string tag);
        rst_n = 1'b0;
        clearInputs();
        #1;
        checkOutput({tag, "_sel"}, 32'(hif.forward_sel), 32'd0);
        checkOutput({tag, "_stall"}, 32'({hif.stall_if, hif.stall_id, hif.bubble_ex}), 32'd0);
        checkOutput({tag, "_flush"}, 32'({hif.flush_if_id, hif.flush_id_ex}), 32'd0);
        checkOutput({tag, "_cnt"}, 32'(hif.pending_cnt), 32'd0);
        checkOutput({tag, "_err"}, 32'(hif.sb_err), 32'd0);
        resetModel();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic randomCycle();
        int a;
        int start;
        clearInputs();
        for (int i = 0; i < NS; i++) begin
            hif.dec_rs_addr[i*A +: A]  = A'($urandom_range(0, 15));
            hif.exec_rs_addr[i*A +: A] = A'($urandom_range(0, 7));
        end
        hif.dec_rs_used  = NS'($urandom);
        hif.dec_rd_addr  = A'($urandom_range(0, 15));
        hif.dec_rd_we    = 1'($urandom);
        hif.dec_is_lc    = 1'($urandom);
        hif.exec_rd_addr = A'($urandom_range(0, 15));
        hif.exec_rd_we   = 1'($urandom);
        hif.exec_is_load = 1'($urandom);
        for (int k = 0; k < NF; k++) hif.fwd_rd_addr[k*A +: A] = A'($urandom_range(0, 7));
        hif.fwd_rd_we = NF'($urandom);
        hif.redirect  = ($urandom_range(0, 9) == 0);
        a = $urandom_range(0, 15);
        if ($urandom_range(0, 2) == 0 && (popcnt() < MP || pend[a])) begin
            hif.lc_issue = 1'b1;
            hif.lc_rd_addr = A'(a);
        end
        if ($urandom_range(0, 59) == 0) begin
            hif.lc_done = 1'b1;
            hif.lc_done_addr = A'($urandom_range(0, 15));
        end else if ($urandom_range(0, 2) == 0 && popcnt() > 0) begin
            start = $urandom_range(0, NR - 1);
            for (int r = 0; r < NR; r++) begin
                if (pend[(start + r) % NR]) begin
                    hif.lc_done = 1'b1;
                    hif.lc_done_addr = A'((start + r) % NR);
                    break;
                end
            end
        end
        applyStimulus();
    endtask

    initial begin
        clearInputs();
        resetModel();
        repeat (2) @(negedge clk);
        doReset("reset");

        // forwarding priority
        hif.exec_rs_addr[A-1:0] = 5'd5;
        hif.fwd_rd_addr = {5'd5, 5'd5};
        hif.fwd_rd_we = 2'b11;
        #1 checkOutput("fwd_young", 32'(hif.forward_sel[SEL_W-1:0]), 32'd1);
        applyStimulus();
        hif.fwd_rd_we = 2'b10;
        #1 checkOutput("fwd_old", 32'(hif.forward_sel[SEL_W-1:0]), 32'd2);
        applyStimulus();
        hif.exec_rs_addr = '0; hif.fwd_rd_addr = '0; hif.fwd_rd_we = 2'b11;
        #1 checkOutput("fwd_x0", 32'(hif.forward_sel[SEL_W-1:0]), 32'd0);
        applyStimulus();

        // load-use
        clearInputs();
        hif.exec_is_load = 1'b1; hif.exec_rd_we = 1'b1; hif.exec_rd_addr = 5'd7;
        hif.dec_rs_addr[A +: A] = 5'd7; hif.dec_rs_used = 2'b10;
        #1 checkOutput("load_use", 32'(hif.stall_if), 32'd1);
        applyStimulus();
        hif.dec_rs_used = 2'b01;
        applyStimulus();

        // scoreboard RAW and same-cycle issue+done
        clearInputs();
        hif.lc_issue = 1'b1; hif.lc_rd_addr = 5'd9;
        applyStimulus();
        clearInputs();
        hif.dec_rs_addr[A-1:0] = 5'd9; hif.dec_rs_used = 2'b01;
        #1 checkOutput("sb_raw", 32'(hif.stall_id), 32'd1);
        applyStimulus();
        applyStimulus();
        hif.lc_done = 1'b1; hif.lc_done_addr = 5'd9;
        applyStimulus();
        hif.lc_done = 1'b0;
        applyStimulus();
        clearInputs();
        hif.lc_issue = 1'b1; hif.lc_rd_addr = 5'd9;
        applyStimulus();
        hif.lc_done = 1'b1; hif.lc_done_addr = 5'd9;
        applyStimulus();
        clearInputs();
        #1 checkOutput("sb_reissue_cnt", 32'(hif.pending_cnt), 32'd1);
        hif.lc_done = 1'b1; hif.lc_done_addr = 5'd9;
        applyStimulus();

        // scoreboard full
        clearInputs();
        for (int r = 10; r < 10 + MP; r++) begin
            hif.lc_issue = 1'b1; hif.lc_rd_addr = A'(r);
            applyStimulus();
        end
        clearInputs();
        hif.dec_is_lc = 1'b1;
        #1 checkOutput("sb_full", 32'(hif.stall_if), 32'd1);
        hif.lc_done = 1'b1; hif.lc_done_addr = 5'd10;
        applyStimulus();
        hif.lc_done = 1'b0;
        #1 checkOutput("sb_full_cnt", 32'(hif.pending_cnt), 32'd3);
        checkOutput("sb_full_drop", 32'(hif.stall_if), 32'd0);
        applyStimulus();
        for (int r = 11; r < 10 + MP; r++) begin
            clearInputs();
            hif.lc_done = 1'b1; hif.lc_done_addr = A'(r);
            applyStimulus();
        end

        // flush masking and re-trigger
        clearInputs();
        hif.exec_is_load = 1'b1; hif.exec_rd_we = 1'b1; hif.exec_rd_addr = 5'd7;
        hif.dec_rs_addr[A +: A] = 5'd7; hif.dec_rs_used = 2'b10;
        hif.redirect = 1'b1;
        #1 checkOutput("flush_mask", 32'({hif.flush_if_id, hif.stall_if}), 32'b10);
        applyStimulus();
        hif.redirect = 1'b0;
        applyStimulus();
        applyStimulus();
        hif.redirect = 1'b1;
        applyStimulus();
        applyStimulus();
        hif.redirect = 1'b0;
        repeat (3) applyStimulus();

        // reset mid-flush with pending ops, then a spurious completion
        clearInputs();
        for (int r = 14; r < 17; r++) begin
            hif.lc_issue = 1'b1; hif.lc_rd_addr = A'(r);
            applyStimulus();
        end
        clearInputs();
        hif.redirect = 1'b1;
        applyStimulus();
        doReset("midflush");
        hif.lc_done = 1'b1; hif.lc_done_addr = 5'd20;
        applyStimulus();
        clearInputs();
        #1 checkOutput("spurious_done", 32'(hif.sb_err), 32'd1);
        applyStimulus();

        doReset("rand_reset");
        for (int n = 0; n < 500; n++) randomCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end
endmodule
